// File: rtl/ctl_resp_pkg.sv
// Shared definitions for the control-strobe responder: FSM encodings and
// default parameter values.
package ctl_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam int LAT_DEF = 3;
    localparam int CW_DEF  = 8;
    // Service timer width; covers the full LAT range of 1..255.
    localparam int TW      = 8;

endpackage

// File: rtl/ctl_resp_cnt.sv
// CW-bit event counter with synchronous clear; SAT selects saturate-at-max
// instead of modulo wrap.
module ctl_resp_cnt
    import ctl_resp_pkg::*;
#(
    parameter int CW  = CW_DEF,
    parameter bit SAT = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_inc,
    input  logic          i_clr,
    output logic [CW-1:0] o_cnt
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] r_cnt;
    logic          w_hold;

    assign w_hold = SAT && (r_cnt == CNT_MAX);

    // Counter register; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_hold) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/ctl_responder.sv
// Request/acknowledge responder: accepts ctl strobes, stays busy LAT cycles,
// acknowledges, and keeps request/drop/sequence statistics.
module ctl_responder
    import ctl_resp_pkg::*;
#(
    parameter int LAT = LAT_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_ctl,
    input  logic          i_done,
    input  logic          i_clr,
    output logic          o_ack,
    output logic          o_busy,
    output logic          o_ovr,
    output logic [CW-1:0] o_req_cnt,
    output logic [CW-1:0] o_drop_cnt,
    output logic [CW-1:0] o_seq_cnt
);

    localparam logic [TW-1:0] TMR_LOAD = TW'(LAT - 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic            w_accept;
    logic            w_drop;
    logic            r_ack;
    logic            r_busy;
    logic            r_ovr;

    // Next-state, timer and request accept/drop decode.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = r_timer;
        w_accept    = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE, ST_ACK: begin
                if (i_ctl) begin
                    w_state_nxt = ST_BUSY;
                    w_timer_nxt = TMR_LOAD;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                w_drop = i_ctl;
                if (r_timer == {TW{1'b0}}) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_state_nxt = ST_BUSY;
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = {TW{1'b0}};
            end
        endcase
    end

    // State register; ack/busy are registered copies of the next state so
    // they track the state exactly with no input-to-output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_timer <= {TW{1'b0}};
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_ack   <= (w_state_nxt == ST_ACK);
            r_busy  <= (w_state_nxt == ST_BUSY);
        end
    end

    // Sticky overrun flag; clear takes priority over a same-cycle drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr <= 1'b0;
        end else if (i_clr) begin
            r_ovr <= 1'b0;
        end else if (w_drop) begin
            r_ovr <= 1'b1;
        end else begin
            r_ovr <= r_ovr;
        end
    end

    ctl_resp_cnt #(.CW(CW), .SAT(1'b0)) u_req_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_accept),
        .i_clr (i_clr),
        .o_cnt (o_req_cnt)
    );

    ctl_resp_cnt #(.CW(CW), .SAT(1'b1)) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_drop),
        .i_clr (i_clr),
        .o_cnt (o_drop_cnt)
    );

    ctl_resp_cnt #(.CW(CW), .SAT(1'b1)) u_seq_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (i_done),
        .i_clr (i_clr),
        .o_cnt (o_seq_cnt)
    );

    assign o_ack  = r_ack;
    assign o_busy = r_busy;
    assign o_ovr  = r_ovr;

endmodule

// File: doc/ctl_responder.md
CTL_RESPONDER -- requirements
Module: ctl_responder

Interface
REQ-001 Parameter LAT, default 3: busy cycles between request acceptance and ack; legal range 1..255.
REQ-002 Parameter CW, default 8: width of all counters.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ctl  input  1  request strobe from initiator; each high cycle is one request.
REQ-006 done  input  1  initiator end-of-sequence marker, one cycle wide.
REQ-007 clr  input  1  synchronous clear of counters and sticky flag.
REQ-008 ack  output  1  registered one-cycle acknowledge of an accepted request.
REQ-009 busy  output  1  registered; high while a request is in service (state BUSY).
REQ-010 ovr  output  1  registered sticky flag; request arrived while BUSY.
REQ-011 req_cnt  output  CW  registered count of accepted requests; wraps modulo 2^CW.
REQ-012 drop_cnt  output  CW  registered count of dropped requests; saturates at 2^CW-1.
REQ-013 seq_cnt  output  CW  registered count of done strobes; saturates at 2^CW-1.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and ACK; unused encodings go to IDLE.
REQ-015 In IDLE, ctl=1 SHALL be accepted: next state BUSY, timer loaded with LAT-1, req_cnt incremented.
REQ-016 In IDLE, ctl=0 SHALL hold IDLE.
REQ-017 In BUSY, when timer=0 the next state SHALL be ACK; otherwise the timer decrements.
REQ-018 In BUSY, ctl=1 SHALL be dropped: drop_cnt incremented (saturating) and ovr set.
REQ-019 In ACK, ack=1 for exactly that cycle; ctl=1 SHALL be accepted (back-to-back) with next state BUSY, timer=LAT-1 and req_cnt incremented; otherwise next state IDLE.
REQ-020 Latency: the ack cycle SHALL be LAT+1 cycles after the accepting ctl cycle (LAT=1: ctl at cycle n, busy at n+1, ack at n+2).
REQ-021 busy SHALL equal (state==BUSY) and ack SHALL equal (state==ACK), both driven from registers with no combinational path from inputs.
REQ-022 done=1 in any state SHALL increment seq_cnt (saturating) and SHALL NOT alter the FSM.
REQ-023 When clr and an increment event occur in the same cycle, clr SHALL win: the counter becomes 0 and ovr becomes 0.
REQ-024 clr SHALL NOT affect FSM state, timer, ack or busy.
REQ-025 When req_cnt equals 2^CW-1, the next accepted request SHALL wrap it to 0.
REQ-026 drop_cnt and seq_cnt SHALL hold at 2^CW-1 once saturated until clr or reset.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, timer 0, ack 0, busy 0, ovr 0, and all counters 0.
REQ-028 Reset asserted mid-service SHALL abandon the request; no ack follows after release.
REQ-029 The first ctl sampled high on a clock edge after rst_n deasserts SHALL be accepted normally.

Structure
REQ-030 Shared package ctl_resp_pkg SHALL hold the state encodings IDLE=0, BUSY=1 and ACK=2 in 2 bits, and the default LAT and CW values.
REQ-031 A single sub-module ctl_resp_cnt (CW-bit counter with inc, clr and a SAT mode select) SHALL be instantiated three times: req_cnt with wrap, drop_cnt and seq_cnt with saturation.
REQ-032 The FSM and timer SHALL be in the top module, with a separate next-state block and a state register.

Verification
REQ-033 LAT=3; single ctl pulse at cycle 0 -> busy high on cycles 1-3, ack high on cycle 4 only, req_cnt=1.
REQ-034 LAT=3; ctl high at cycles 0 and 2 -> one ack at cycle 4, drop_cnt=1, ovr=1, req_cnt=1.
REQ-035 LAT=1; ctl high on the ack cycle -> busy on the next cycle, second ack 2 cycles after the first, req_cnt=2.
REQ-036 CW=4; 17 accepted requests -> req_cnt=1; 20 done strobes -> seq_cnt=15.
REQ-037 clr in the same cycle as a dropped ctl -> drop_cnt=0 and ovr=0 on the next cycle.
REQ-038 rst_n pulsed low during BUSY -> outputs 0 asynchronously, no ack afterwards; a new ctl is accepted after release.
